// File: rtl/fifo_pkg.sv
// Shared types, default sizes and pointer helpers for the arbitrated write FIFO controller.
package fifo_pkg;

  localparam int unsigned DATASIZE = 8;
  localparam int unsigned ADDRSIZE = 4;

  typedef logic [ADDRSIZE:0]   ptr_t;
  typedef logic [ADDRSIZE-1:0] addr_t;

  // Full when the wrap bits differ and the address bits match.
  function automatic logic ptr_full(input ptr_t w, input ptr_t r);
    return (w[ADDRSIZE] != r[ADDRSIZE]) && (w[ADDRSIZE-1:0] == r[ADDRSIZE-1:0]);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_ctrl_rr_arbiter.sv
// Round-robin arbiter: zero-cycle one-hot grant, rotating priority pointer.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            wclk,
  input  logic            wrst_n,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   prio
);

  logic [PW-1:0] idx;
  logic [PW-1:0] gidx;
  logic [PW-1:0] prio_nxt;
  logic          found;

  // Search req starting at prio, wrapping to 0; first hit wins when enabled.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PW'((32'(prio) + i) % NREQ);
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
    prio_nxt = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
  end

  // Priority moves just past the winner; holds when nothing is granted.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      prio <= '0;
    end else if (found) begin
      prio <= prio_nxt;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter_ctrl.sv
// FIFO controller sharing the memory write port among NREQ requesters.
module fifo_wr_arbiter_ctrl
  import fifo_pkg::*;
#(
  parameter  int unsigned DATASIZE = fifo_pkg::DATASIZE,
  parameter  int unsigned ADDRSIZE = fifo_pkg::ADDRSIZE,
  parameter  int unsigned NREQ     = 4,
  localparam int unsigned PTRW     = ADDRSIZE + 1
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          grant,
  input  logic                     rinc,
  output logic                     rempty,
  output logic                     wfull,
  output logic [ADDRSIZE:0]        count,
  output logic                     underflow_err,
  output logic [DATASIZE-1:0]      mem_wdata,
  output logic [ADDRSIZE-1:0]      mem_waddr,
  output logic                     mem_wclken,
  output logic [ADDRSIZE-1:0]      mem_raddr
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [ADDRSIZE:0] wptr;
  logic [ADDRSIZE:0] rptr;
  logic [ADDRSIZE:0] wptr_nxt;
  logic [ADDRSIZE:0] rptr_nxt;
  logic              wen;
  logic              ren;
  logic              full_nxt;
  logic              arb_en;
  logic [PW-1:0]     prio;

  // Grants are held off while full and while reset is asserted.
  assign arb_en = wrst_n & ~wfull;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .req    (req),
    .enable (arb_en),
    .grant  (grant),
    .prio   (prio)
  );

  assign wen      = |grant;
  assign ren      = rinc & ~rempty;
  assign wptr_nxt = wptr + PTRW'(wen);
  assign rptr_nxt = rptr + PTRW'(ren);

  // Full detection on next-state pointers.
  generate
    if (ADDRSIZE == fifo_pkg::ADDRSIZE) begin : g_pkg_full
      assign full_nxt = ptr_full(ptr_t'(wptr_nxt), ptr_t'(rptr_nxt));
    end else begin : g_local_full
      assign full_nxt = (wptr_nxt[ADDRSIZE] != rptr_nxt[ADDRSIZE]) &&
                        (wptr_nxt[ADDRSIZE-1:0] == rptr_nxt[ADDRSIZE-1:0]);
    end
  endgenerate

  // Pointers and registered status derived from next-state pointers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      wfull         <= 1'b0;
      count         <= '0;
      underflow_err <= 1'b0;
    end else begin
      wptr          <= wptr_nxt;
      rptr          <= rptr_nxt;
      rempty        <= (wptr_nxt == rptr_nxt);
      wfull         <= full_nxt;
      count         <= wptr_nxt - rptr_nxt;
      underflow_err <= underflow_err | (rinc & rempty);
    end
  end

  // Select the granted requester's data word (grant is one-hot).
  always_comb begin
    mem_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        mem_wdata = mem_wdata | req_data[i*DATASIZE +: DATASIZE];
      end
    end
  end

  assign mem_waddr  = wptr[ADDRSIZE-1:0];
  assign mem_raddr  = rptr[ADDRSIZE-1:0];
  assign mem_wclken = wen;

endmodule

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
// Scoreboard bench for fifo_wr_arbiter_ctrl: directed stimulus, decoupled monitor.
module tb_fifo_wr_arbiter_ctrl;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic        rinc;
  logic        rempty;
  logic        wfull;
  logic [4:0]  count;
  logic        underflow_err;
  logic [7:0]  mem_wdata;
  logic [3:0]  mem_waddr;
  logic        mem_wclken;
  logic [3:0]  mem_raddr;

  fifo_wr_arbiter_ctrl #(.DATASIZE(8), .ADDRSIZE(4), .NREQ(4)) dut (
    .wclk          (wclk),
    .wrst_n        (wrst_n),
    .req           (req),
    .req_data      (req_data),
    .grant         (grant),
    .rinc          (rinc),
    .rempty        (rempty),
    .wfull         (wfull),
    .count         (count),
    .underflow_err (underflow_err),
    .mem_wdata     (mem_wdata),
    .mem_waddr     (mem_waddr),
    .mem_wclken    (mem_wclken),
    .mem_raddr     (mem_raddr)
  );

  always #5 wclk = ~wclk;

  // Environment memory: dual-port, async read.
  logic [7:0] tbmem [16];
  always @(posedge wclk) begin
    if (mem_wclken) tbmem[mem_waddr] <= mem_wdata;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct { logic [3:0] g; logic [3:0] a; logic [7:0] d; } wexp_t;
  typedef struct { logic [3:0] a; logic [7:0] d; } rexp_t;
  wexp_t wq[$];
  rexp_t rq[$];
  wexp_t we;
  rexp_t re;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each accepted write also yields a later read of the same word.
  task automatic push_wr(input logic [3:0] g, input logic [3:0] a, input logic [7:0] d);
    wexp_t w;
    rexp_t r;
    w.g = g; w.a = a; w.d = d;
    r.a = a; r.d = d;
    wq.push_back(w);
    rq.push_back(r);
  endtask

  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  // Monitor: pop and compare whenever a write or a pop is presented.
  always @(negedge wclk) begin
    if (mem_wclken) begin
      if (wq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", mem_waddr, mem_wdata);
      end else begin
        we = wq.pop_front();
        chk("wr_grant", 32'(grant), 32'(we.g));
        chk("wr_addr", 32'(mem_waddr), 32'(we.a));
        chk("wr_data", 32'(mem_wdata), 32'(we.d));
      end
    end
    if (wrst_n && rinc && !rempty) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_read: got addr 0x%0h expected none", mem_raddr);
      end else begin
        re = rq.pop_front();
        chk("rd_addr", 32'(mem_raddr), 32'(re.a));
        chk("rd_data", 32'(tbmem[mem_raddr]), 32'(re.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wrst_n   = 1'b0;
    req      = 4'hF;
    rinc     = 1'b0;
    req_data = 32'h13121110;
    repeat (3) @(posedge wclk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_rempty", 32'(rempty), 1);
    chk("rst_wfull", 32'(wfull), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_uflow", 32'(underflow_err), 0);
    chk("rst_wclken", 32'(mem_wclken), 0);

    // Round-robin fill with all requesters active.
    for (int k = 0; k < 16; k++) push_wr(4'(1 << (k % 4)), 4'(k), 8'(8'h10 + k % 4));
    wrst_n = 1'b1;
    #1;
    chk("first_grant", 32'(grant), 1);
    repeat (16) cyc();
    chk("fill_wfull", 32'(wfull), 1);
    chk("fill_count", 32'(count), 16);
    chk("fill_grant", 32'(grant), 0);
    chk("fill_rempty", 32'(rempty), 0);
    req = 4'h0;

    // Drain.
    rinc = 1'b1;
    repeat (16) cyc();
    rinc = 1'b0;
    chk("drain_rempty", 32'(rempty), 1);
    chk("drain_count", 32'(count), 0);
    chk("drain_wfull", 32'(wfull), 0);

    // Wrap: write 10, read 10, write 10.
    for (int k = 0; k < 10; k++) begin
      req = 4'b0010;
      req_data[15:8] = 8'(8'hA0 + k);
      push_wr(4'b0010, 4'(k), 8'(8'hA0 + k));
      cyc();
    end
    req = 4'h0;
    rinc = 1'b1;
    repeat (10) cyc();
    rinc = 1'b0;
    chk("wrap_mid_count", 32'(count), 0);
    for (int k = 0; k < 10; k++) begin
      req = 4'b0010;
      req_data[15:8] = 8'(8'hB0 + k);
      push_wr(4'b0010, 4'(10 + k), 8'(8'hB0 + k));
      cyc();
    end
    req = 4'h0;
    chk("wrap_count", 32'(count), 10);
    chk("wrap_wfull", 32'(wfull), 0);

    // Top up to full.
    for (int k = 0; k < 6; k++) begin
      req = 4'b0001;
      req_data[7:0] = 8'(8'hC0 + k);
      push_wr(4'b0001, 4'(4 + k), 8'(8'hC0 + k));
      cyc();
    end
    req = 4'h0;
    chk("top_wfull", 32'(wfull), 1);
    chk("top_count", 32'(count), 16);

    // Full + rinc + req: pop first, grant the following cycle.
    req = 4'b0100;
    req_data[23:16] = 8'hD0;
    rinc = 1'b1;
    #1;
    chk("full_rd_grant", 32'(grant), 0);
    cyc();
    rinc = 1'b0;
    chk("full_rd_count", 32'(count), 15);
    chk("full_rd_wfull", 32'(wfull), 0);
    push_wr(4'b0100, 4'd10, 8'hD0);
    #1;
    chk("full_next_grant", 32'(grant), 32'h4);
    cyc();
    req = 4'h0;
    chk("refill_count", 32'(count), 16);
    chk("refill_wfull", 32'(wfull), 1);

    // Drain everything.
    rinc = 1'b1;
    repeat (16) cyc();
    rinc = 1'b0;
    chk("drain2_rempty", 32'(rempty), 1);
    chk("drain2_uflow", 32'(underflow_err), 0);

    // Empty + write + rinc: read ignored and flagged, write proceeds.
    req = 4'b0001;
    req_data[7:0] = 8'hE0;
    rinc = 1'b1;
    push_wr(4'b0001, 4'd11, 8'hE0);
    cyc();
    req = 4'h0;
    rinc = 1'b0;
    chk("uflow_set", 32'(underflow_err), 1);
    chk("uflow_rempty", 32'(rempty), 0);
    chk("uflow_count", 32'(count), 1);
    chk("uflow_raddr", 32'(mem_raddr), 11);
    cyc();
    chk("uflow_sticky", 32'(underflow_err), 1);

    // Burst up to count=7, then reset mid-cycle with a request pending.
    for (int k = 0; k < 6; k++) begin
      req = 4'b0001;
      req_data[7:0] = 8'(8'hF0 + k);
      push_wr(4'b0001, 4'(12 + k), 8'(8'hF0 + k));
      cyc();
    end
    chk("burst_count", 32'(count), 7);
    #2;
    wrst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_rempty", 32'(rempty), 1);
    chk("arst_uflow", 32'(underflow_err), 0);
    chk("arst_wfull", 32'(wfull), 0);
    chk("arst_grant", 32'(grant), 0);
    chk("arst_wq_empty", 32'(wq.size()), 0);
    rq.delete();

    // After release prio restarts at 0: req0 beats req3.
    req = 4'b1001;
    req_data[7:0] = 8'h5A;
    push_wr(4'b0001, 4'd0, 8'h5A);
    cyc();
    wrst_n = 1'b1;
    cyc();
    req = 4'h0;
    chk("post_rst_count", 32'(count), 1);
    chk("post_rst_rempty", 32'(rempty), 0);
    rinc = 1'b1;
    cyc();
    rinc = 1'b0;
    chk("final_rempty", 32'(rempty), 1);

    repeat (2) cyc();
    chk("wq_left", 32'(wq.size()), 0);
    chk("rq_left", 32'(rq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
